// File: rtl/shiftreg_pkg.sv
// Shared mode codes, FSM state encodings and helpers for the sequenced shift register.
package shiftreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_ROR  = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_SHR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Hold, load and clear give the same result however often they repeat.
    function automatic logic is_one_shot(input logic [2:0] mode);
        return (mode == MODE_HOLD) || (mode == MODE_LOAD) || (mode == MODE_CLR);
    endfunction

endpackage

// File: rtl/shiftreg_step.sv
// One combinational step of the shift register.
// Serves both the idle single-step path and the multi-step RUN path.
module shiftreg_step
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    input  logic             so,
    output logic [WIDTH-1:0] next_q,
    output logic             next_so
);

    always_comb begin
        next_q  = q;
        next_so = so;
        case (mode)
            MODE_HOLD: ;
            MODE_LOAD: next_q = d;
            MODE_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                next_so = q[0];
            end
            MODE_SHL: begin
                next_q  = {q[WIDTH-2:0], si};
                next_so = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q  = {si, q[WIDTH-1:1]};
                next_so = q[0];
            end
            MODE_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                next_so = q[WIDTH-1];
            end
            MODE_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                next_so = q[0];
            end
            MODE_CLR: next_q = '0;
        endcase
    end

endmodule

// File: rtl/shiftreg_seq.sv
// Shift register with single-step modes and a counted multi-step sequencer.
// A start in IDLE latches mode, count and load data; RUN steps, DONE pulses done.
module shiftreg_seq
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       m,
    input  logic             si,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state;
    logic [2:0]       mode_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] data_r;

    logic             in_run;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] next_q;
    logic             next_so;

    // In RUN the live m and d are ignored; the latched copies drive the step.
    assign in_run    = (state == ST_RUN);
    assign step_mode = in_run ? mode_r : m;
    assign step_d    = in_run ? data_r : d;

    shiftreg_step #(.WIDTH(WIDTH)) u_step (
        .mode    (step_mode),
        .si      (si),
        .d       (step_d),
        .q       (q),
        .so      (so),
        .next_q  (next_q),
        .next_so (next_so)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            mode_r <= MODE_HOLD;
            cnt_r  <= '0;
            data_r <= '0;
            q      <= '0;
            so     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= m;
                        cnt_r  <= cnt;
                        data_r <= d;
                        state  <= (cnt == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        q  <= next_q;
                        so <= next_so;
                    end
                end
                ST_RUN: begin
                    q  <= next_q;
                    so <= next_so;
                    if ((cnt_r == CNT_W'(1)) || is_one_shot(mode_r)) begin
                        cnt_r <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shiftreg_seq.sv
// Directed bench for shiftreg_seq (WIDTH=8, CNT_W=4): single-step vector table
// plus hand-written multi-step, boundary and mid-operation reset sequences.
module tb_shiftreg_seq;

    logic       clk;
    logic       rst;
    logic [2:0] m;
    logic       si;
    logic [7:0] d;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    shiftreg_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .m     (m),
        .si    (si),
        .d     (d),
        .start (start),
        .cnt   (cnt),
        .q     (q),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m;
        logic       si;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_so;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic single_step(input logic [2:0] mode, input logic [7:0] data);
        @(negedge clk);
        m = mode;
        d = data;
        si = 1'b0;
        start = 1'b0;
        @(negedge clk);
        m = 3'b000;
    endtask

    // Start at one edge, then watch busy/done each cycle until IDLE (bounded).
    task automatic run_multi(input string name, input logic [2:0] mode, input logic [3:0] n,
                             input logic [7:0] data, input int extra_starts,
                             input int exp_busy, input logic [7:0] exp_q);
        int busy_cycles;
        int done_pulses;
        @(negedge clk);
        m = mode;
        cnt = n;
        d = data;
        start = 1'b1;
        busy_cycles = 0;
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) done_pulses++;
            if (!busy) break;
            start = (i < extra_starts);
            m = 3'b111;
            d = 8'($urandom_range(0, 255));
            cnt = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        m = 3'b000;
        check({name, " busy_cycles"}, busy_cycles, exp_busy);
        check({name, " done_pulses"}, done_pulses, 1);
        check({name, " q"}, q, exp_q);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        m = 3'b000;
        si = 1'b0;
        d = 8'h00;
        start = 1'b0;
        cnt = 4'd0;

        vecs[0] = '{3'b001, 1'b0, 8'hB5, 8'hB5, 1'b0};
        vecs[1] = '{3'b011, 1'b1, 8'h00, 8'h6B, 1'b1};
        vecs[2] = '{3'b010, 1'b0, 8'h00, 8'hB5, 1'b1};
        vecs[3] = '{3'b000, 1'b1, 8'hFF, 8'hB5, 1'b1};
        vecs[4] = '{3'b111, 1'b1, 8'hFF, 8'h00, 1'b1};
        vecs[5] = '{3'b001, 1'b1, 8'h90, 8'h90, 1'b1};
        vecs[6] = '{3'b110, 1'b1, 8'h00, 8'hC8, 1'b0};
        vecs[7] = '{3'b100, 1'b1, 8'h00, 8'hE4, 1'b0};
        vecs[8] = '{3'b101, 1'b0, 8'h00, 8'hC9, 1'b1};
        vecs[9] = '{3'b011, 1'b0, 8'h00, 8'h92, 1'b1};

        #12;
        check("reset q", q, 8'h00);
        check("reset so", so, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            m = vecs[i].m;
            si = vecs[i].si;
            d = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d so", i), so, vecs[i].exp_so);
            check($sformatf("vec%0d busy", i), busy, 1'b0);
            check($sformatf("vec%0d done", i), done, 1'b0);
        end

        single_step(3'b001, 8'h81);
        run_multi("rol3", 3'b101, 4'd3, 8'h00, 0, 4, 8'h0C);

        single_step(3'b001, 8'h90);
        run_multi("asr2", 3'b110, 4'd2, 8'h00, 0, 3, 8'hE4);

        single_step(3'b001, 8'h01);
        run_multi("ror9", 3'b010, 4'd9, 8'h00, 0, 10, 8'h80);

        single_step(3'b001, 8'h5A);
        run_multi("cnt0", 3'b010, 4'd0, 8'h00, 0, 1, 8'h5A);

        run_multi("load_once", 3'b001, 4'd5, 8'h3C, 0, 2, 8'h3C);

        single_step(3'b001, 8'h81);
        run_multi("restart_ignored", 3'b101, 4'd3, 8'h00, 2, 4, 8'h0C);
        @(negedge clk);
        check("restart_ignored idle", busy, 1'b0);

        single_step(3'b001, 8'h81);
        @(negedge clk);
        m = 3'b101;
        cnt = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 3'b000;
        @(negedge clk);
        check("midrun q before reset", q, 8'h03);
        #2;
        rst = 1'b0;
        #1;
        check("midrun reset q", q, 8'h00);
        check("midrun reset busy", busy, 1'b0);
        check("midrun reset done", done, 1'b0);
        check("midrun reset so", so, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        m = 3'b001;
        d = 8'hA5;
        @(negedge clk);
        m = 3'b000;
        check("post reset load q", q, 8'hA5);
        check("post reset busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftreg_seq.md
SHIFTREG_SEQ -- requirements
Module: shiftreg_seq

Interface
REQ-001 Parameter WIDTH, default 8, is the register width, legal range 2 to 32.
REQ-002 Parameter CNT_W, default 4, is the width of the step-count input.
REQ-003 Port clk, input, 1 bit, is the single clock, and all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, is the asynchronous, active-low reset.
REQ-005 Port m, input, 3 bits, selects the mode: 000 hold, 001 load, 010 rotate right, 011 shift left, 100 logical shift right, 101 rotate left, 110 arithmetic shift right, 111 clear.
REQ-006 Port si, input, 1 bit, is serial-in; it is used by modes 011 and 100 only.
REQ-007 Port d, input, WIDTH bits, is parallel load data.
REQ-008 Port start, input, 1 bit, requests a multi-step operation.
REQ-009 Port cnt, input, CNT_W bits, is the number of steps for a multi-step operation.
REQ-010 Port q, output, WIDTH bits, is the register contents.
REQ-011 Port so, output, 1 bit, is the bit most recently shifted or rotated out.
REQ-012 Port busy, output, 1 bit, is high whenever the state is not IDLE.
REQ-013 Port done, output, 1 bit, is a one-cycle completion pulse.

Function
REQ-014 The state machine SHALL have three states, IDLE, RUN and DONE, and SHALL use one-hot or binary encoding from the package.
REQ-015 In IDLE with start=0, each edge SHALL apply mode m once (single-step behaviour), leave done=0, and keep the state in IDLE.
REQ-016 Per-mode step: 011 gives q<={q[W-2:0],si} and so<=q[W-1]; 100 gives q<={si,q[W-1:1]} and so<=q[0]; 010 and 110 give so<=q[0]; 101 gives so<=q[W-1]; 110 replicates q[W-1].
REQ-017 In modes 000, 001 and 111, so SHALL hold its value.
REQ-018 In IDLE with start=1, the edge SHALL latch m into mode_r and cnt into the step counter, SHALL NOT modify q, and SHALL move to RUN, or to DONE if cnt=0.
REQ-019 A latched mode in {000, 001, 111} SHALL execute exactly once, regardless of cnt.
REQ-020 In RUN, each edge SHALL perform one step of mode_r and decrement the counter; the edge at which the counter reaches 0 SHALL move to DONE.
REQ-021 A start at edge k with cnt=N>0 SHALL update q on edges k+1 through k+N, hold done=1 for the single cycle after edge k+N, and return to IDLE at edge k+N+1.
REQ-022 In RUN and DONE, m, start and d SHALL be ignored, while si SHALL be sampled live on each step.
REQ-023 A cnt greater than WIDTH SHALL perform all cnt steps, with no modulo reduction.

Reset
REQ-024 rst=0 SHALL, without waiting for a clock edge, force q=0, so=0, counter=0, mode_r=000, state IDLE, busy=0 and done=0, including in the middle of an operation.
REQ-025 After rst deasserts, the first rising edge SHALL be treated as an IDLE cycle.

Structure
REQ-026 Package shiftreg_pkg SHALL hold the mode code constants and state encodings.
REQ-027 Sub-module shiftreg_step SHALL be combinational, taking mode, si and q and producing next_q and next_so, and SHALL be shared by the single-step and RUN paths.
REQ-028 The counter width SHALL equal CNT_W, with no arithmetic wider than CNT_W.

Verification (WIDTH=8, CNT_W=4)
REQ-029 Single-step: load d=0xB5 -> q=0xB5; then m=011 with si=1 -> q=0x6B and so=1; then m=010 -> q=0xB5 and so=1.
REQ-030 Multi-step rotate: q=0x81, start with m=101 and cnt=3 -> busy high for 4 cycles, q=0x0C, done pulses exactly once.
REQ-031 Arithmetic shift and wrap: q=0x90, start with m=110 and cnt=2 -> q=0xE4; q=0x01, start with m=010 and cnt=9 -> q=0x80.
REQ-032 Boundaries: start with cnt=0 -> done pulse on the next cycle and q unchanged; a second start while busy -> ignored and no extra done.
REQ-033 Reset mid-operation: rst=0 during the second RUN step -> q=0x00, busy=0 and done=0 immediately; after release, single-step load works normally.
